// File: rtl/id_imm_gen_pipe.sv
// ID-stage immediate decoder (I/S/B/U/J, optional CSR zimm under ID_IMM_ZICSR_EN),
// sign-extended to XLEN and registered behind a valid/ready handshake with a 2-entry skid buffer.
module id_imm_gen_pipe #(
  parameter int XLEN      = 32,
  parameter int PASS_INST = 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [31:0]     out_inst
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef struct packed {
    logic [2:0]      fmt;
    logic [XLEN-1:0] imm;
    logic [31:0]     inst;
  } entry_t;

  // Returns {fmt, imm32}; every format fits in 32 bits before the final sign extension.
  function automatic logic [34:0] decode_imm(input logic [31:0] inst);
    logic [2:0]  fmt;
    logic [31:0] imm;
    fmt = FMT_NONE;
    imm = 32'h0000_0000;
    case (inst[6:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_MISC_MEM: begin
        fmt = FMT_I;
        imm = {{20{inst[31]}}, inst[31:20]};
      end
      OPC_STORE: begin
        fmt = FMT_S;
        imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OPC_BRANCH: begin
        fmt = FMT_B;
        imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        fmt = FMT_U;
        imm = {inst[31:12], 12'h000};
      end
      OPC_JAL: begin
        fmt = FMT_J;
        imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
`ifdef ID_IMM_ZICSR_EN
      OPC_SYSTEM: begin
        if (inst[14]) begin
          fmt = FMT_Z;
          imm = {27'h000_0000, inst[19:15]};
        end else begin
          fmt = FMT_NONE;
          imm = 32'h0000_0000;
        end
      end
`else
      OPC_SYSTEM: begin
        fmt = FMT_NONE;
        imm = 32'h0000_0000;
      end
`endif
      default: begin
        fmt = FMT_NONE;
        imm = 32'h0000_0000;
      end
    endcase
    return {fmt, imm};
  endfunction

  logic [34:0]        dec_raw_s;
  logic signed [31:0] dec_imm32_s;
  entry_t             dec_entry_s;
  logic               accept_s;

  entry_t main_r;
  entry_t skid_r;
  logic   main_valid_r;
  logic   skid_valid_r;
  logic   in_ready_r;

  logic   main_valid_nxt_s;
  logic   skid_valid_nxt_s;
  logic   main_load_s;
  logic   main_from_skid_s;
  logic   skid_load_s;

  // Combinational decode of the incoming word into a buffer entry.
  always_comb begin
    dec_raw_s        = decode_imm(in_inst);
    dec_imm32_s      = dec_raw_s[31:0];
    dec_entry_s.fmt  = dec_raw_s[34:32];
    dec_entry_s.imm  = XLEN'(dec_imm32_s);
    dec_entry_s.inst = (PASS_INST != 0) ? in_inst : 32'h0000_0000;
  end

  assign accept_s = in_valid && in_ready_r;

  // Next-state of the two-entry buffer; flush wins over every transfer.
  always_comb begin
    main_valid_nxt_s = main_valid_r;
    skid_valid_nxt_s = skid_valid_r;
    main_load_s      = 1'b0;
    main_from_skid_s = 1'b0;
    skid_load_s      = 1'b0;
    if (flush) begin
      main_valid_nxt_s = 1'b0;
      skid_valid_nxt_s = 1'b0;
    end else if (!main_valid_r || out_ready) begin
      if (skid_valid_r) begin
        main_valid_nxt_s = 1'b1;
        main_load_s      = 1'b1;
        main_from_skid_s = 1'b1;
        skid_valid_nxt_s = accept_s;
        skid_load_s      = accept_s;
      end else begin
        main_valid_nxt_s = accept_s;
        main_load_s      = accept_s;
        main_from_skid_s = 1'b0;
        skid_valid_nxt_s = 1'b0;
        skid_load_s      = 1'b0;
      end
    end else begin
      // Main is stalled: a new word can only park in the skid slot.
      if (accept_s) begin
        skid_valid_nxt_s = 1'b1;
        skid_load_s      = 1'b1;
      end else begin
        skid_valid_nxt_s = skid_valid_r;
        skid_load_s      = 1'b0;
      end
    end
  end

  // Buffer state; in_ready is registered from the next skid occupancy.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      main_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b1;
      main_r       <= '0;
      skid_r       <= '0;
    end else begin
      main_valid_r <= main_valid_nxt_s;
      skid_valid_r <= skid_valid_nxt_s;
      in_ready_r   <= !skid_valid_nxt_s;
      if (main_load_s) begin
        main_r <= main_from_skid_s ? skid_r : dec_entry_s;
      end
      if (skid_load_s) begin
        skid_r <= dec_entry_s;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = main_valid_r;
  assign out_imm   = main_r.imm;
  assign out_fmt   = main_r.fmt;
  assign out_inst  = main_r.inst;

endmodule

// File: tb/tb_id_imm_gen_pipe.sv
// Directed bench for id_imm_gen_pipe: XLEN=32 and XLEN=64 instances share the inputs.
module tb_id_imm_gen_pipe;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] in_inst;

  logic        in_ready32, out_valid32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic [31:0] inst32;

  logic        in_ready64, out_valid64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [31:0] inst64;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] inst;
    logic [2:0]  fmt;
    logic [31:0] imm32;
    logic [63:0] imm64;
  } vec_t;

  vec_t vecs [15];

  id_imm_gen_pipe #(.XLEN(32), .PASS_INST(1)) dut32 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready32), .in_inst(in_inst),
    .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(imm32), .out_fmt(fmt32), .out_inst(inst32)
  );

  id_imm_gen_pipe #(.XLEN(64), .PASS_INST(1)) dut64 (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready64), .in_inst(in_inst),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(imm64), .out_fmt(fmt64), .out_inst(inst64)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    vecs[0]  = '{32'hFFF00093, 3'd1, 32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFF};
    vecs[1]  = '{32'hFE112E23, 3'd2, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC};
    vecs[2]  = '{32'hFE000CE3, 3'd3, 32'hFFFFFFF8, 64'hFFFFFFFF_FFFFFFF8};
    vecs[3]  = '{32'h001000EF, 3'd5, 32'h00000800, 64'h00000000_00000800};
    vecs[4]  = '{32'h123452B7, 3'd4, 32'h12345000, 64'h00000000_12345000};
    vecs[5]  = '{32'h800002B7, 3'd4, 32'h80000000, 64'hFFFFFFFF_80000000};
`ifdef ID_IMM_ZICSR_EN
    vecs[6]  = '{32'h3400D073, 3'd6, 32'h00000001, 64'h00000000_00000001};
`else
    vecs[6]  = '{32'h3400D073, 3'd0, 32'h00000000, 64'h00000000_00000000};
`endif
    vecs[7]  = '{32'h00000073, 3'd0, 32'h00000000, 64'h00000000_00000000};
    vecs[8]  = '{32'h002081B3, 3'd0, 32'h00000000, 64'h00000000_00000000};
    vecs[9]  = '{32'h7FF12083, 3'd1, 32'h000007FF, 64'h00000000_000007FF};
    vecs[10] = '{32'h80012083, 3'd1, 32'hFFFFF800, 64'hFFFFFFFF_FFFFF800};
    vecs[11] = '{32'hFFFFF297, 3'd4, 32'hFFFFF000, 64'hFFFFFFFF_FFFFF000};
    vecs[12] = '{32'h000080E7, 3'd1, 32'h00000000, 64'h00000000_00000000};
    vecs[13] = '{32'h0FF0000F, 3'd1, 32'h000000FF, 64'h00000000_000000FF};
    vecs[14] = '{32'hFFDFF06F, 3'd5, 32'hFFFFFFFC, 64'hFFFFFFFF_FFFFFFFC};

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_inst = 32'h0;
    #2;
    chk("rst_valid", {63'd0, out_valid32}, 64'd0);
    chk("rst_ready", {63'd0, in_ready32}, 64'd1);
    chk("rst_imm", {32'd0, imm32}, 64'd0);
    chk("rst_fmt", {61'd0, fmt32}, 64'd0);
    chk("rst_inst", {32'd0, inst32}, 64'd0);
    chk("rst_imm64", imm64, 64'd0);
    step();
    reset = 1'b0;
    step();

    // Back-to-back stream, one word per cycle, no stalls.
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1;
      in_inst  = vecs[i].inst;
      step();
      chk($sformatf("v%0d_valid", i), {63'd0, out_valid32}, 64'd1);
      chk($sformatf("v%0d_fmt", i), {61'd0, fmt32}, {61'd0, vecs[i].fmt});
      chk($sformatf("v%0d_imm32", i), {32'd0, imm32}, {32'd0, vecs[i].imm32});
      chk($sformatf("v%0d_imm64", i), imm64, vecs[i].imm64);
      chk($sformatf("v%0d_fmt64", i), {61'd0, fmt64}, {61'd0, vecs[i].fmt});
      chk($sformatf("v%0d_inst", i), {32'd0, inst32}, {32'd0, vecs[i].inst});
      chk($sformatf("v%0d_ready", i), {63'd0, in_ready32}, 64'd1);
    end
    in_valid = 1'b0;
    step();
    chk("drain_valid", {63'd0, out_valid32}, 64'd0);

    // Backpressure: A, B accepted, C refused while stalled.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'hFFF00093;
    step();
    chk("bp_a_valid", {63'd0, out_valid32}, 64'd1);
    chk("bp_a_ready", {63'd0, in_ready32}, 64'd1);
    in_inst = 32'hFE112E23;
    step();
    chk("bp_b_inst", {32'd0, inst32}, 64'h00000000_FFF00093);
    chk("bp_b_ready", {63'd0, in_ready32}, 64'd0);
    in_inst = 32'hFE000CE3;
    step();
    chk("bp_c_inst", {32'd0, inst32}, 64'h00000000_FFF00093);
    chk("bp_c_imm", {32'd0, imm32}, 64'h00000000_FFFFFFFF);
    chk("bp_c_ready", {63'd0, in_ready32}, 64'd0);
    out_ready = 1'b1;
    step();
    chk("rel_b_valid", {63'd0, out_valid32}, 64'd1);
    chk("rel_b_inst", {32'd0, inst32}, 64'h00000000_FE112E23);
    chk("rel_b_fmt", {61'd0, fmt32}, 64'd2);
    step();
    chk("rel_c_valid", {63'd0, out_valid32}, 64'd1);
    chk("rel_c_inst", {32'd0, inst32}, 64'h00000000_FE000CE3);
    chk("rel_c_imm", {32'd0, imm32}, 64'h00000000_FFFFFFF8);
    in_valid = 1'b0;
    step();
    chk("rel_empty", {63'd0, out_valid32}, 64'd0);

    // Flush with both entries held.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h123452B7;
    step();
    in_inst = 32'h001000EF;
    step();
    chk("fl_full_ready", {63'd0, in_ready32}, 64'd0);
    chk("fl_full_inst", {32'd0, inst32}, 64'h00000000_123452B7);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_valid", {63'd0, out_valid32}, 64'd0);
    chk("fl_ready", {63'd0, in_ready32}, 64'd1);
    chk("fl_valid64", {63'd0, out_valid64}, 64'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("fl_no_ghost", {63'd0, out_valid32}, 64'd0);

    // Flush discards a same-cycle accept.
    in_valid = 1'b1; in_inst = 32'hFFF00093; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_acc_valid", {63'd0, out_valid32}, 64'd0);
    step();
    chk("fl_acc_later", {63'd0, out_valid32}, 64'd0);

    // Asynchronous reset with two entries held.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'hFFF00093;
    step();
    in_inst = 32'hFE112E23;
    step();
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("ar_valid", {63'd0, out_valid32}, 64'd0);
    chk("ar_ready", {63'd0, in_ready32}, 64'd1);
    chk("ar_inst", {32'd0, inst32}, 64'd0);
    step();
    reset = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1; in_inst = 32'h123452B7;
    step();
    in_valid = 1'b0;
    chk("ar_post_inst", {32'd0, inst32}, 64'h00000000_123452B7);
    chk("ar_post_imm", {32'd0, imm32}, 64'h00000000_12345000);
    step();
    chk("ar_post_empty", {63'd0, out_valid32}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
